// File: rtl/rf_writeback_unit.sv
// rf_writeback_unit: merges ALU results and in-order load responses
// onto the single register file write port, with load-use busy tracking.
module rf_writeback_unit #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_BITS = 5,
    parameter int LD_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  LdIssue,
    input  logic [DEPTH_BITS-1:0] LdRd,
    input  logic [2:0]            LdFunct3,
    input  logic [1:0]            LdAddrLow,
    output logic                  LdReady,
    input  logic                  MemRspValid,
    input  logic [WIDTH-1:0]      MemRspData,
    input  logic                  AluValid,
    input  logic [DEPTH_BITS-1:0] AluRd,
    input  logic [WIDTH-1:0]      AluData,
    output logic                  AluReady,
    input  logic [DEPTH_BITS-1:0] ChkAddr1,
    input  logic [DEPTH_BITS-1:0] ChkAddr2,
    output logic                  Busy1,
    output logic                  Busy2,
    output logic                  WrEn,
    output logic [DEPTH_BITS-1:0] WrAddress,
    output logic [WIDTH-1:0]      WrData,
    output logic                  RspError
);

    localparam int LB = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;

    logic [DEPTH_BITS-1:0] q_rd [LD_DEPTH];
    logic [2:0]            q_f3 [LD_DEPTH];
    logic [1:0]            q_al [LD_DEPTH];
    logic [LB-1:0]         wp, rp;
    logic [LB:0]           cnt;

    logic                  hold_v;
    logic [DEPTH_BITS-1:0] hold_rd;
    logic [WIDTH-1:0]      hold_data;

    logic push, pop;
    logic sel_ld, sel_hold, sel_alu, cap;
    logic                  wr_n;
    logic [DEPTH_BITS-1:0] wa_n;
    logic [WIDTH-1:0]      wd_n;
    logic [WIDTH-1:0]      ld_fmt;
    logic [7:0]            bsel;
    logic [15:0]           hsel;

    assign LdReady  = (cnt != (LB+1)'(LD_DEPTH));
    assign push     = LdIssue && LdReady;
    assign pop      = MemRspValid && (cnt != '0);
    assign AluReady = AluValid && !hold_v;

    assign sel_ld   = pop;
    assign sel_hold = !pop && hold_v;
    assign sel_alu  = !pop && !hold_v && AluValid;
    // A losing ALU result parks in hold; x0 results are simply dropped.
    assign cap      = pop && AluValid && !hold_v && (AluRd != '0);

    // Extract and extend the addressed byte/half from the response word.
    always_comb begin
        bsel   = MemRspData[8*q_al[rp] +: 8];
        hsel   = MemRspData[16*q_al[rp][1] +: 16];
        ld_fmt = MemRspData;
        case (q_f3[rp])
            3'b000:  ld_fmt = {{(WIDTH-8){bsel[7]}}, bsel};
            3'b001:  ld_fmt = {{(WIDTH-16){hsel[15]}}, hsel};
            3'b100:  ld_fmt = {{(WIDTH-8){1'b0}}, bsel};
            3'b101:  ld_fmt = {{(WIDTH-16){1'b0}}, hsel};
            default: ld_fmt = MemRspData;
        endcase
    end

    // Pick the write for next cycle: load response, then hold, then ALU.
    always_comb begin
        wr_n = 1'b0;
        wa_n = '0;
        wd_n = '0;
        unique case (1'b1)
            sel_ld: begin
                wr_n = (q_rd[rp] != '0);
                wa_n = q_rd[rp];
                wd_n = ld_fmt;
            end
            sel_hold: begin
                wr_n = 1'b1;
                wa_n = hold_rd;
                wd_n = hold_data;
            end
            sel_alu: begin
                wr_n = (AluRd != '0);
                wa_n = AluRd;
                wd_n = AluData;
            end
            default: ;
        endcase
    end

    // Load queue pointers, count and entry storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < LD_DEPTH; i++) begin
                q_rd[i] <= '0;
                q_f3[i] <= '0;
                q_al[i] <= '0;
            end
        end else begin
            if (push) begin
                q_rd[wp] <= LdRd;
                q_f3[wp] <= LdFunct3;
                q_al[wp] <= LdAddrLow;
                wp       <= wp + 1'b1;
            end
            if (pop)
                rp <= rp + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

    // Hold register for an ALU result displaced by a load write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_v    <= 1'b0;
            hold_rd   <= '0;
            hold_data <= '0;
        end else if (cap) begin
            hold_v    <= 1'b1;
            hold_rd   <= AluRd;
            hold_data <= AluData;
        end else if (sel_hold) begin
            hold_v    <= 1'b0;
        end
    end

    // Registered write port and sticky stray-response flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WrEn      <= 1'b0;
            WrAddress <= '0;
            WrData    <= '0;
            RspError  <= 1'b0;
        end else begin
            WrEn <= wr_n;
            if (wr_n) begin
                WrAddress <= wa_n;
                WrData    <= wd_n;
            end
            if (MemRspValid && (cnt == '0))
                RspError <= 1'b1;
        end
    end

    // Busy: any pending queue entry, held result or uncommitted write.
    always_comb begin
        logic [LB-1:0] off;
        logic          b1, b2;
        b1  = 1'b0;
        b2  = 1'b0;
        off = '0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            off = LB'(i) - rp;
            if ({1'b0, off} < cnt) begin
                if (q_rd[i] == ChkAddr1) b1 = 1'b1;
                if (q_rd[i] == ChkAddr2) b2 = 1'b1;
            end
        end
        if (hold_v && hold_rd == ChkAddr1) b1 = 1'b1;
        if (hold_v && hold_rd == ChkAddr2) b2 = 1'b1;
        if (WrEn && WrAddress == ChkAddr1) b1 = 1'b1;
        if (WrEn && WrAddress == ChkAddr2) b2 = 1'b1;
        Busy1 = b1 && (ChkAddr1 != '0);
        Busy2 = b2 && (ChkAddr2 != '0);
    end

endmodule
